// File: rtl/fifo_pkg.sv
// Shared widths and types for the single-clock byte FIFO.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    typedef logic [FIFO_ADDR_WIDTH:0]   ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0]   cnt_t;
    typedef logic [FIFO_DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/sync_fifo8_if.sv
// Producer/consumer handshake bundle for sync_fifo8.
interface sync_fifo8_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port memory: synchronous write, registered read (BRAM-inferable).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Array is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo8.sv
// Single-clock byte FIFO with occupancy count, threshold flags and sticky
// overflow/underflow errors. Flags are registered from next-count.
module sync_fifo8
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic       clk,
    input  logic       reset,
    sync_fifo8_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] ONE       = 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_nxt;
    logic                wr_ok;
    logic                rd_ok;

    assign wr_ok = bus.wr_en & ~bus.full;
    assign rd_ok = bus.rd_en & ~bus.empty;

    always_comb begin
        count_nxt = bus.count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = bus.count + ONE;
            2'b01:   count_nxt = bus.count - ONE;
            default: count_nxt = bus.count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.count        <= '0;
            bus.rd_valid     <= 1'b0;
            bus.empty        <= 1'b1;
            bus.full         <= 1'b0;
            bus.almost_empty <= 1'b1;
            bus.almost_full  <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ONE;
            if (rd_ok) rd_ptr <= rd_ptr + ONE;
            bus.count        <= count_nxt;
            bus.rd_valid     <= rd_ok;
            bus.empty        <= (count_nxt == '0);
            bus.full         <= (count_nxt == DEPTH_CNT);
            bus.almost_empty <= (count_nxt <= AE_CNT);
            bus.almost_full  <= (count_nxt >= AF_CNT);
            // A fresh error in the same cycle wins over the clear.
            if (bus.wr_en & bus.full)   bus.overflow  <= 1'b1;
            else if (bus.err_clr)       bus.overflow  <= 1'b0;
            if (bus.rd_en & bus.empty)  bus.underflow <= 1'b1;
            else if (bus.err_clr)       bus.underflow <= 1'b0;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok & ~reset),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (bus.wr_data),
        .re    (rd_ok & ~reset),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (bus.rd_data)
    );
endmodule
